// File: rtl/mem_pkg.sv
// Shared definitions for the memory arbiter: owner-tag encoding of the
// read in flight and the default starvation limit for the fetch port.
package mem_pkg;

   // Which port issued the read whose data arrives next cycle.
   typedef enum logic [1:0] {
      OWN_NONE = 2'b00,
      OWN_IF   = 2'b01,
      OWN_D    = 2'b10
   } owner_t;

   // Consecutive denied fetch cycles before fetch is forced through.
   localparam int STARVE_MAX_DEF = 3;

endpackage : mem_pkg

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous memory.
// The data port normally wins, but a fetch denied STARVE_MAX cycles in a
// row is forced through. Read data comes back one cycle after the grant
// and is steered to the port recorded in the owner tag.
//
// Handshake: a requester raises req with addr/we/wdata and holds them
// stable until it sees its gnt high; the request is accepted in that
// cycle. Read data returns with rvalid=1 exactly one cycle after the grant.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 16,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] Address,
   output logic [DATA_W-1:0] DataIn,
   output logic              MemWrite,
   input  logic [DATA_W-1:0] MemVal
);

   // At least two bits so the counter can always represent STARVE_MAX.
   localparam int CNT_W = ($clog2(STARVE_MAX + 1) < 2) ? 2 : $clog2(STARVE_MAX + 1);

   logic [CNT_W-1:0]  starve_cnt;
   owner_t            owner;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] d_rdata_q;
   logic              starved;

   assign starved = (starve_cnt == CNT_W'(STARVE_MAX));

   // Grant decision: data wins ties unless fetch has starved; nothing is
   // granted while reset is high so the memory cannot be written.
   always_comb begin
      if_gnt = 1'b0;
      d_gnt  = 1'b0;
      if (!reset) begin
         if (d_req && !(if_req && starved)) begin
            d_gnt = 1'b1;
         end else if (if_req) begin
            if_gnt = 1'b1;
         end
      end
   end

   // Memory-side drive: granted port's address, otherwise the last one.
   always_comb begin
      MemWrite = d_gnt & d_we;
      if (d_gnt) begin
         Address = d_addr;
      end else if (if_gnt) begin
         Address = if_addr;
      end else begin
         Address = addr_q;
      end
      DataIn = MemWrite ? d_wdata : wdata_q;
   end

   // Return path: live memory data on the owning port, held value otherwise.
   always_comb begin
      if_rvalid = (owner == OWN_IF);
      d_rvalid  = (owner == OWN_D);
      if_rdata  = if_rvalid ? MemVal : if_rdata_q;
      d_rdata   = d_rvalid  ? MemVal : d_rdata_q;
   end

   // Starvation counter: counts denied fetch cycles, saturating at the limit.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         starve_cnt <= '0;
      end else if (!if_req || if_gnt) begin
         starve_cnt <= '0;
      end else if (!starved) begin
         starve_cnt <= starve_cnt + CNT_W'(1);
      end
   end

   // Owner tag of the read in flight; stores and idle cycles leave none.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         owner <= OWN_NONE;
      end else if (if_gnt) begin
         owner <= OWN_IF;
      end else if (d_gnt && !d_we) begin
         owner <= OWN_D;
      end else begin
         owner <= OWN_NONE;
      end
   end

   // Hold registers so address, write data and read data stay put when idle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         addr_q     <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         addr_q     <= Address;
         wdata_q    <= DataIn;
         if_rdata_q <= if_rdata;
         d_rdata_q  <= d_rdata;
      end
   end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small synchronous memory model.
module tb_mem_arbiter;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 16;

   logic              clock = 1'b0;
   logic              reset;
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;
   logic [ADDR_W-1:0] Address;
   logic [DATA_W-1:0] DataIn;
   logic              MemWrite;
   logic [DATA_W-1:0] MemVal;

   // program-load side of the memory model
   logic              ld_en;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_data;

   int n_checks = 0;
   int n_fail   = 0;

   mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_MAX(3)) dut (
      .clock(clock), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .Address(Address), .DataIn(DataIn), .MemWrite(MemWrite), .MemVal(MemVal)
   );

   // clock/reset block
   always #5 clock = ~clock;

   // memory model: registered read, read-before-write, synchronous load port
   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
   always_ff @(posedge clock) begin
      if (ld_en) begin
         mem[ld_addr] <= ld_data;
      end else if (MemWrite) begin
         mem[Address] <= DataIn;
      end
      MemVal <= mem[Address];
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic ireq, input logic [ADDR_W-1:0] iaddr,
                        input logic dreq, input logic dwe,
                        input logic [ADDR_W-1:0] daddr, input logic [DATA_W-1:0] dwd);
      if_req  = ireq;
      if_addr = iaddr;
      d_req   = dreq;
      d_we    = dwe;
      d_addr  = daddr;
      d_wdata = dwd;
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v);
      ld_en = 1'b1; ld_addr = a; ld_data = v;
      next_cycle();
      ld_en = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " if_gnt"},    if_gnt,    1'b0);
      check({tag, " d_gnt"},     d_gnt,     1'b0);
      check({tag, " MemWrite"},  MemWrite,  1'b0);
      check({tag, " if_rvalid"}, if_rvalid, 1'b0);
      check({tag, " d_rvalid"},  d_rvalid,  1'b0);
      check({tag, " if_rdata"},  if_rdata,  16'h0);
      check({tag, " d_rdata"},   d_rdata,   16'h0);
      check({tag, " Address"},   Address,   16'h0);
      check({tag, " DataIn"},    DataIn,    16'h0);
   endtask

   logic [DATA_W-1:0] fexp [4] = '{16'h0008, 16'h0814, 16'h8014, 16'h8838};
   logic [7:0]        d_pat    = 8'b0111_0111;  // bit i: data wins cycle i
   logic [3:0]        d_pat2   = 4'b0111;

   initial begin
      reset = 1'b1;
      ld_en = 1'b0; ld_addr = '0; ld_data = '0;
      idle();
      next_cycle();
      preload(16'd0, 16'h0008);
      preload(16'd1, 16'h0814);
      preload(16'd2, 16'h8014);
      preload(16'd3, 16'h8838);
      preload(16'h10, 16'hAAAA);
      preload(16'h20, 16'h5555);

      // reset state with both ports requesting (store on data port)
      drive(1'b1, 16'd7, 1'b1, 1'b1, 16'd9, 16'hBEEF);
      @(negedge clock);
      check_all_zero("rst");
      next_cycle();
      idle();

      // fetch reads at 0..3, first grant right after reset release
      reset = 1'b0;
      drive(1'b1, 16'd0, 1'b0, 1'b0, '0, '0);
      @(negedge clock);
      check("f0 if_gnt", if_gnt, 1'b1);
      check("f0 Address", Address, 16'd0);
      check("f0 if_rvalid", if_rvalid, 1'b0);
      for (int i = 1; i < 4; i++) begin
         next_cycle();
         drive(1'b1, ADDR_W'(i), 1'b0, 1'b0, '0, '0);
         @(negedge clock);
         check("fN if_gnt", if_gnt, 1'b1);
         check("fN Address", Address, 32'(i));
         check("fN if_rvalid", if_rvalid, 1'b1);
         check("fN if_rdata", if_rdata, fexp[i-1]);
      end
      next_cycle();
      idle();
      @(negedge clock);
      check("f4 if_rvalid", if_rvalid, 1'b1);
      check("f4 if_rdata", if_rdata, 16'h8838);
      check("f4 Address hold", Address, 16'd3);
      next_cycle();
      @(negedge clock);
      check("f5 if_rvalid", if_rvalid, 1'b0);
      check("f5 if_rdata hold", if_rdata, 16'h8838);

      // store 0x1234 @200 then load 200
      next_cycle();
      drive(1'b0, '0, 1'b1, 1'b1, 16'd200, 16'h1234);
      @(negedge clock);
      check("st d_gnt", d_gnt, 1'b1);
      check("st MemWrite", MemWrite, 1'b1);
      check("st DataIn", DataIn, 16'h1234);
      check("st Address", Address, 16'd200);
      next_cycle();
      drive(1'b0, '0, 1'b1, 1'b0, 16'd200, 16'h0);
      @(negedge clock);
      check("ld d_gnt", d_gnt, 1'b1);
      check("ld MemWrite", MemWrite, 1'b0);
      check("ld d_rvalid", d_rvalid, 1'b0);
      check("ld if_rvalid", if_rvalid, 1'b0);
      next_cycle();
      idle();
      @(negedge clock);
      check("ld3 d_rvalid", d_rvalid, 1'b1);
      check("ld3 d_rdata", d_rdata, 16'h1234);
      check("ld3 MemWrite", MemWrite, 1'b0);
      check("ld3 Address hold", Address, 16'd200);
      next_cycle();
      @(negedge clock);
      check("ld4 d_rvalid", d_rvalid, 1'b0);
      check("ld4 d_rdata hold", d_rdata, 16'h1234);

      // both ports load continuously for 8 cycles
      for (int i = 0; i < 8; i++) begin
         next_cycle();
         drive(1'b1, 16'h10, 1'b1, 1'b0, 16'h20, 16'h0);
         @(negedge clock);
         check("arb d_gnt", d_gnt, d_pat[i]);
         check("arb if_gnt", if_gnt, !d_pat[i]);
         check("arb Address", Address, d_pat[i] ? 16'h20 : 16'h10);
         if (i > 0) begin
            check("arb d_rvalid", d_rvalid, d_pat[i-1]);
            check("arb if_rvalid", if_rvalid, !d_pat[i-1]);
            if (d_pat[i-1]) check("arb d_rdata", d_rdata, 16'h5555);
            else            check("arb if_rdata", if_rdata, 16'hAAAA);
         end
      end
      next_cycle();
      idle();
      @(negedge clock);
      check("arb8 if_rvalid", if_rvalid, 1'b1);
      check("arb8 if_rdata", if_rdata, 16'hAAAA);
      check("arb8 d_rvalid", d_rvalid, 1'b0);

      // starvation count clears when fetch drops its request
      for (int i = 0; i < 2; i++) begin
         next_cycle();
         drive(1'b1, 16'h10, 1'b1, 1'b0, 16'h20, 16'h0);
         @(negedge clock);
         check("clr pre d_gnt", d_gnt, 1'b1);
      end
      next_cycle();
      drive(1'b0, 16'h10, 1'b1, 1'b0, 16'h20, 16'h0);
      @(negedge clock);
      check("clr gap d_gnt", d_gnt, 1'b1);
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         drive(1'b1, 16'h10, 1'b1, 1'b0, 16'h20, 16'h0);
         @(negedge clock);
         check("clr post d_gnt", d_gnt, d_pat2[i]);
         check("clr post if_gnt", if_gnt, !d_pat2[i]);
      end

      // reset arrives mid-cycle while a read is granted
      next_cycle();
      drive(1'b1, 16'd1, 1'b0, 1'b0, '0, '0);
      @(negedge clock);
      check("mr if_gnt", if_gnt, 1'b1);
      #1;
      reset = 1'b1;
      drive(1'b1, 16'd1, 1'b1, 1'b1, 16'd5, 16'hDEAD);
      #1;
      check_all_zero("mr");
      next_cycle();
      @(negedge clock);
      check_all_zero("mr2");
      next_cycle();
      reset = 1'b0;
      idle();
      @(negedge clock);
      check("mr3 if_rvalid", if_rvalid, 1'b0);
      check("mr3 d_rvalid", d_rvalid, 1'b0);

      // interleaved fetch read, data store, data load
      next_cycle();
      drive(1'b1, 16'd2, 1'b0, 1'b0, '0, '0);
      @(negedge clock);
      check("il1 if_gnt", if_gnt, 1'b1);
      check("il1 if_rvalid", if_rvalid, 1'b0);
      check("il1 d_rvalid", d_rvalid, 1'b0);
      next_cycle();
      drive(1'b0, '0, 1'b1, 1'b1, 16'd300, 16'h7777);
      @(negedge clock);
      check("il2 if_rvalid", if_rvalid, 1'b1);
      check("il2 if_rdata", if_rdata, 16'h8014);
      check("il2 d_rvalid", d_rvalid, 1'b0);
      check("il2 MemWrite", MemWrite, 1'b1);
      check("il2 DataIn", DataIn, 16'h7777);
      next_cycle();
      drive(1'b0, '0, 1'b1, 1'b0, 16'd300, 16'h0);
      @(negedge clock);
      check("il3 if_rvalid", if_rvalid, 1'b0);
      check("il3 d_rvalid", d_rvalid, 1'b0);
      check("il3 MemWrite", MemWrite, 1'b0);
      next_cycle();
      idle();
      @(negedge clock);
      check("il4 d_rvalid", d_rvalid, 1'b1);
      check("il4 d_rdata", d_rdata, 16'h7777);
      check("il4 if_rvalid", if_rvalid, 1'b0);
      next_cycle();
      @(negedge clock);
      check("il5 d_rvalid", d_rvalid, 1'b0);
      check("il5 if_rvalid", if_rvalid, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_mem_arbiter
